// File: rtl/bram_reader_pkg.sv
// bram_reader_pkg: FSM states and output buffer depth shared by the BRAM stream reader.
package bram_reader_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
    localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/bram_skid_buf.sv
// bram_skid_buf: 2-entry FIFO of data+last words with flush; head is visible without a pop.
module bram_skid_buf
    import bram_reader_pkg::*;
#(
    parameter int DATA = 72
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [DATA-1:0] push_data,
    input  logic            push_last,
    input  logic            pop,
    input  logic            flush,
    output logic [DATA-1:0] head_data,
    output logic            head_last,
    output logic [1:0]      count
);
    localparam int PW = $clog2(SKID_DEPTH);

    logic [DATA-1:0]       data_q [SKID_DEPTH];
    logic [SKID_DEPTH-1:0] last_q;
    logic [PW-1:0]         wr_ptr, rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SKID_DEPTH; i++) data_q[i] <= '0;
            last_q <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= push_data;
                last_q[wr_ptr] <= push_last;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];
endmodule

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: reads base..base+len-1 from a 1-cycle-latency BRAM port into a valid/ready stream.
// Define BRAM_READER_WRAP_EN to repeat the burst from base until aborted.
module bram_stream_reader
    import bram_reader_pkg::*;
#(
    parameter int DATA = 72,
    parameter int ADDR = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [ADDR-1:0] base,
    input  logic [ADDR:0]   len,
    input  logic            abort,
    output logic            busy,
    output logic            done,
    output logic [ADDR-1:0] mem_addr,
    output logic            mem_rd,
    input  logic [DATA-1:0] mem_dout,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DATA-1:0] out_data,
    output logic            out_last
);
`ifdef BRAM_READER_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    state_t          state, state_nxt;
    logic [ADDR-1:0] base_q, nxt_addr, cur_addr, cur_base;
    logic [ADDR:0]   len_q, issue_cnt, cur_cnt, cur_len;
    logic [2:0]      credit;
    logic [1:0]      count;
    logic [DATA-1:0] head_data;
    logic            head_last, rd_q, last_m, last_q, bypass, pop, push, kill;
    logic            launch, issue, wrap_pt, done_nxt;

    // With the buffer empty the word on mem_dout goes straight out, so the
    // BRAM output register acts as the third credit needed for 1 word/cycle.
    assign bypass    = count == 2'd0;
    assign out_valid = !bypass || rd_q;
    assign out_data  = (bypass && rd_q) ? mem_dout : head_data;
    assign out_last  = bypass ? rd_q && last_q : head_last;
    assign pop       = out_valid && out_ready;
    assign push      = rd_q && !(bypass && pop);
    assign busy      = state != IDLE;
    assign kill      = abort && busy;
    assign credit    = {1'b0, count} + {2'b0, rd_q} + {2'b0, mem_rd};

    always_comb begin
        launch    = state == IDLE && start && !abort && len != '0;
        cur_cnt   = launch ? '0 : issue_cnt;
        cur_len   = launch ? len : len_q;
        cur_base  = launch ? base : base_q;
        cur_addr  = launch ? base : nxt_addr;
        wrap_pt   = cur_cnt == cur_len - (ADDR+1)'(1);
        issue     = launch || (state == RUN && !abort && issue_cnt != len_q
                               && credit < 3'd2 + {2'b0, pop});
        state_nxt = state;
        done_nxt  = 1'b0;
        if (kill) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
        end else if (state == IDLE) begin
            state_nxt = launch ? RUN : IDLE;
            done_nxt  = start && !abort && len == '0;
        end else if (!WRAP && pop && out_last) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
        end else if (state == RUN && issue_cnt == len_q) begin
            state_nxt = DRAIN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q    <= '0;
            len_q     <= '0;
            nxt_addr  <= '0;
            issue_cnt <= '0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            rd_q      <= 1'b0;
            last_m    <= 1'b0;
            last_q    <= 1'b0;
            done      <= 1'b0;
        end else begin
            done   <= done_nxt;
            mem_rd <= issue;
            rd_q   <= mem_rd && !kill;
            last_m <= issue && wrap_pt;
            last_q <= last_m;
            if (launch) begin
                base_q <= base;
                len_q  <= len;
            end
            if (issue) begin
                mem_addr  <= cur_addr;
                nxt_addr  <= (WRAP && wrap_pt) ? cur_base : cur_addr + ADDR'(1);
                issue_cnt <= (WRAP && wrap_pt) ? '0 : cur_cnt + (ADDR+1)'(1);
            end
        end
    end

    bram_skid_buf #(.DATA(DATA)) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (mem_dout),
        .push_last (last_q),
        .pop       (pop && !bypass),
        .flush     (kill),
        .head_data (head_data),
        .head_last (head_last),
        .count     (count)
    );
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: directed checks of the BRAM stream reader against a mem[i]=i BRAM model.
module tb_bram_stream_reader;
    logic        clk, rst_n, start, abort, busy, done, mem_rd, out_valid, out_ready, out_last;
    logic [9:0]  base, mem_addr;
    logic [10:0] len;
    logic [71:0] mem_dout, out_data;
    logic [71:0] mem [1024];
    int          n_checks = 0;
    int          n_fail = 0;

    bram_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base      (base),
        .len       (len),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_dout  (mem_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd) mem_dout <= mem[mem_addr];

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input int b, input int l);
        @(negedge clk);
        base  = b[9:0];
        len   = l[10:0];
        start = 1'b1;
        settle();
        start = 1'b0;
    endtask

    // Per cycle: read address order, credit bound, data/last order, hold-under-stall.
    task automatic collect(input int n_words, input int b, input int n_len, input bit rnd,
                           input bit wrap, input int limit);
        int          rd_idx = 0, pk = 0, cyc = 0, popped = 0;
        bit          held = 0;
        logic [71:0] hd = '0;
        logic        hl = 1'b0;
        while (pk < n_words && cyc < limit) begin
            @(negedge clk);
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hd);
                check("hold_last", out_last, hl);
            end
            if (mem_rd) begin
                if (!wrap) check("rd_in_range", rd_idx < n_len, 1);
                check("rd_addr", mem_addr, (b + rd_idx % n_len) % 1024);
                rd_idx++;
            end
            check("credit", rd_idx - popped <= 2, 1);
            if (wrap) check("wrap_busy", busy, 1);
            check("no_early_done", done, 0);
            if (out_valid && out_ready) begin
                check("data", out_data, (b + pk % n_len) % 1024);
                check("last", out_last, pk % n_len == n_len - 1);
                pk++;
                popped++;
            end
            held = out_valid && !out_ready;
            hd   = out_data;
            hl   = out_last;
        end
        if (pk < n_words) check("timeout_words", pk, n_words);
    endtask

    task automatic expect_done();
        settle();
        @(negedge clk);
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("done_valid", out_valid, 0);
        @(negedge clk);
        check("done_clear", done, 0);
    endtask

    task automatic do_abort();
        @(negedge clk);
        abort = 1'b1;
        settle();
        abort = 1'b0;
        @(negedge clk);
        check("abort_valid", out_valid, 0);
        check("abort_rd", mem_rd, 0);
        check("abort_done", done, 1);
        check("abort_busy", busy, 0);
        @(negedge clk);
        check("abort_done_clear", done, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 72'(i);
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; base = '0; len = '0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd", mem_rd, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_last", out_last, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
`ifdef BRAM_READER_WRAP_EN
        launch(2, 3);
        collect(9, 2, 3, 1'b0, 1'b1, 40);
        settle();
        do_abort();
`else
        // base=5 len=4, ready high: cycle-exact latency, data, last, done, busy
        out_ready = 1'b1;
        launch(5, 4);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            check("b_valid", out_valid, k >= 2 && k <= 5);
            if (k >= 2 && k <= 5) begin
                check("b_data", out_data, 3 + k);
                check("b_last", out_last, k == 5);
            end
            check("b_done", done, k == 6);
            check("b_busy", busy, k <= 5);
            check("b_rd", mem_rd, k <= 4);
        end
        launch(0, 256);
        collect(256, 0, 256, 1'b1, 1'b0, 3000);
        expect_done();
        launch(1022, 4);
        collect(4, 1022, 4, 1'b0, 1'b0, 20);
        expect_done();
        launch(7, 1024);
        collect(1024, 7, 1024, 1'b0, 1'b0, 1200);
        expect_done();
        // len=0: done only, no reads
        launch(9, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check("z_done", done, k == 1);
            check("z_busy", busy, 0);
            check("z_rd", mem_rd, 0);
            check("z_valid", out_valid, 0);
        end
        // abort together with start in IDLE
        @(negedge clk);
        base = 10'd50; len = 11'd5; start = 1'b1; abort = 1'b1;
        settle();
        start = 1'b0; abort = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check("as_done", done, 0);
            check("as_busy", busy, 0);
            check("as_rd", mem_rd, 0);
            check("as_valid", out_valid, 0);
        end
        // three words accepted, stall, abort, then a fresh burst
        launch(100, 10);
        collect(3, 100, 10, 1'b0, 1'b0, 20);
        settle();
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("stall_busy", busy, 1);
        do_abort();
        launch(200, 3);
        collect(3, 200, 3, 1'b0, 1'b0, 20);
        expect_done();
        // asynchronous reset mid-burst
        launch(0, 20);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mr_busy", busy, 0);
        check("mr_rd", mem_rd, 0);
        check("mr_valid", out_valid, 0);
        check("mr_addr", mem_addr, 0);
        settle();
        rst_n = 1'b1;
        @(negedge clk);
        check("mr_done", done, 0);
        check("mr_busy_after", busy, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
